ifetch_unit: RTL and testbench

- Instruction-fetch stage: owns the PC and runs a request/ready handshake with instruction memory.
- Produces the if_pc / if_inst / if_valid stream that the IF/ID pipeline register samples every clock.
- Accepts stall and branch-redirect feedback from the decode/control side.
- Implements MIPS delay-slot semantics: the instruction already presented on if_* when a branch resolves is kept; the in-flight fetch is squashed.

---
 rtl/ifetch_unit.sv | 137 +++++++++++++
 tb/tb_ifetch_unit.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_unit.sv
// Instruction-fetch stage: owns the PC, handshakes with instruction memory and
// presents if_pc/if_inst/if_valid with MIPS delay-slot squash. Optional macro: IFETCH_PERF_CNT_EN.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_INC   = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_flag,
  input  logic [31:0] branch_target,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_valid
`ifdef IFETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_count
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD} state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] target_reg, target_next;
  logic        squash_reg, squash_next;
  logic [31:0] buf_pc_reg, buf_pc_next;
  logic [31:0] buf_inst_reg, buf_inst_next;
  logic        mem_req_reg;
  logic [31:0] if_pc_reg, if_inst_reg;
  logic        if_valid_reg;
  logic        deliver;
  logic [31:0] del_pc, del_inst;

  always_comb begin
    state_next    = state_reg;
    pc_next       = pc_reg;
    target_next   = target_reg;
    squash_next   = squash_reg;
    buf_pc_next   = buf_pc_reg;
    buf_inst_next = buf_inst_reg;
    deliver       = 1'b0;
    del_pc        = if_pc_reg;
    del_inst      = if_inst_reg;
    case (state_reg)
      S_IDLE: begin
        state_next = S_REQ;
        if (branch_flag) pc_next = branch_target;
      end
      S_REQ: begin
        if (mem_ready) begin
          if (squash_reg || branch_flag) begin
            // A branch arriving on the completion edge beats any older pending target.
            squash_next = 1'b0;
            pc_next     = branch_flag ? branch_target : target_reg;
          end else if (stall) begin
            buf_pc_next   = pc_reg;
            buf_inst_next = mem_rdata;
            pc_next       = pc_reg + PC_INC;
            state_next    = S_HOLD;
          end else begin
            deliver  = 1'b1;
            del_pc   = pc_reg;
            del_inst = mem_rdata;
            pc_next  = pc_reg + PC_INC;
          end
        end else if (branch_flag) begin
          // Keep the outstanding request intact; it is dropped once it completes.
          target_next = branch_target;
          squash_next = 1'b1;
        end
      end
      S_HOLD: begin
        if (branch_flag) begin
          pc_next    = branch_target;
          state_next = S_REQ;
        end else if (!stall) begin
          deliver    = 1'b1;
          del_pc     = buf_pc_reg;
          del_inst   = buf_inst_reg;
          state_next = S_REQ;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      pc_reg       <= RESET_PC;
      target_reg   <= RESET_PC;
      squash_reg   <= 1'b0;
      buf_pc_reg   <= 32'h0;
      buf_inst_reg <= 32'h0;
      mem_req_reg  <= 1'b0;
      if_pc_reg    <= 32'h0;
      if_inst_reg  <= 32'h0;
      if_valid_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      pc_reg       <= pc_next;
      target_reg   <= target_next;
      squash_reg   <= squash_next;
      buf_pc_reg   <= buf_pc_next;
      buf_inst_reg <= buf_inst_next;
      mem_req_reg  <= (state_next == S_REQ);
      if (!stall) begin
        if_pc_reg    <= deliver ? del_pc : if_pc_reg;
        if_inst_reg  <= deliver ? del_inst : 32'h0;
        if_valid_reg <= deliver;
      end
    end
  end

  assign mem_req  = mem_req_reg;
  assign mem_addr = pc_reg;
  assign if_pc    = if_pc_reg;
  assign if_inst  = if_inst_reg;
  assign if_valid = if_valid_reg;

`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] fetch_count_reg;

  always_ff @(posedge clk) begin
    if (rst) fetch_count_reg <= 32'h0;
    else if (deliver && !stall) fetch_count_reg <= fetch_count_reg + 32'd1;
  end

  assign fetch_count = fetch_count_reg;
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// Scoreboarded bench for ifetch_unit: expected requests and deliveries are queued
// by the stimulus and popped by independent monitors at each clock edge.
module tb_ifetch_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        branch_flag = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata;
  logic [31:0] if_pc, if_inst;
  logic        if_valid;
`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] fetch_count;
`endif

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] req_q[$];
  logic [31:0] exp_q[$];
  bit          mon_en = 1'b1;
  int          cnt = 0;
  logic        mon_stall, mon_rst, mon_on;
  logic [31:0] exp_pc;

  always #5 clk = ~clk;

  ifetch_unit dut (
    .clk(clk), .rst(rst), .stall(stall),
    .branch_flag(branch_flag), .branch_target(branch_target),
    .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .if_pc(if_pc), .if_inst(if_inst), .if_valid(if_valid)
`ifdef IFETCH_PERF_CNT_EN
    , .fetch_count(fetch_count)
`endif
  );

  // Memory model: data is a function of the address, some addresses answer late.
  assign mem_rdata = mem_addr ^ 32'hA5A5_0000;

  function automatic int lat_of(input logic [31:0] a);
    case (a)
      32'h8:   return 3;
      32'h20:  return 2;
      default: return 0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst || !mem_req || mem_ready) cnt <= 0;
    else cnt <= cnt + 1;
  end

  always @(negedge clk) mem_ready <= mem_req && (cnt >= lat_of(mem_addr));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  // Request monitor: each completed handshake must match the next queued address.
  always @(posedge clk) begin
    if (mon_en && !rst && mem_req && mem_ready) begin
      if (req_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL req_unexpected: got addr %h expected none", mem_addr);
      end else begin
        chk("req_addr", mem_addr, req_q.pop_front());
      end
    end
  end

  // Delivery monitor: a new instruction is presented when if_valid rises on a non-stalled edge.
  always @(posedge clk) begin
    mon_stall = stall;
    mon_rst   = rst;
    mon_on    = mon_en;
    #1;
    if (mon_on && !mon_stall && !mon_rst && if_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL deliver_unexpected: got pc %h expected none", if_pc);
      end else begin
        exp_pc = exp_q.pop_front();
        chk("deliver_pc", if_pc, exp_pc);
        chk("deliver_inst", if_inst, exp_pc ^ 32'hA5A5_0000);
      end
    end
  end

  task automatic wait_req(input logic [31:0] a);
    int n = 0;
    while (!(mem_req && mem_addr == a) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      n_cmp++; n_err++;
      $display("FAIL wait_req: got no request, expected addr %h within 200 cycles", a);
    end
  endtask

  initial begin
    req_q = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14, 32'h18, 32'h1C, 32'h20,
              32'h400, 32'h404, 32'hFFFF_FFFC, 32'h0, 32'h4};
    exp_q = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14, 32'h18, 32'h1C,
              32'h400, 32'hFFFF_FFFC, 32'h0, 32'h4};

    repeat (2) @(negedge clk);
    chk("rst_mem_req", {31'h0, mem_req}, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_if_valid", {31'h0, if_valid}, 32'h0);
    chk("rst_if_pc", if_pc, 32'h0);
    chk("rst_if_inst", if_inst, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("first_req", {31'h0, mem_req}, 32'h1);
    chk("first_addr", mem_addr, 32'h0);

    // Slow memory on 0x8: request held stable, bubbles presented meanwhile.
    wait_req(32'h8);
    repeat (3) begin
      @(negedge clk);
      chk("wait_req_hi", {31'h0, mem_req}, 32'h1);
      chk("wait_addr", mem_addr, 32'h8);
      chk("wait_bubble_valid", {31'h0, if_valid}, 32'h0);
      chk("wait_bubble_inst", if_inst, 32'h0);
    end

    // Stall across the completion of 0x10.
    wait_req(32'h10);
    chk("pre_stall_pc", if_pc, 32'hC);
    stall = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("stall_hold_pc", if_pc, 32'hC);
      chk("stall_hold_valid", {31'h0, if_valid}, 32'h1);
      chk("stall_hold_req", {31'h0, mem_req}, 32'h0);
    end
    stall = 1'b0;
    @(negedge clk);
    chk("release_pc", if_pc, 32'h10);
    chk("release_next_addr", mem_addr, 32'h14);
    chk("release_next_req", {31'h0, mem_req}, 32'h1);

    // Branch while 0x20 is still in flight.
    wait_req(32'h20);
    chk("slot_pc", if_pc, 32'h1C);
    chk("slot_valid", {31'h0, if_valid}, 32'h1);
    branch_flag = 1'b1; branch_target = 32'h400;
    @(negedge clk);
    branch_flag = 1'b0;
    chk("br_inflight_addr", mem_addr, 32'h20);
    chk("br_inflight_req", {31'h0, mem_req}, 32'h1);
    chk("br_inflight_valid", {31'h0, if_valid}, 32'h0);
    wait_req(32'h400);
    chk("squash_valid", {31'h0, if_valid}, 32'h0);

    // Branch on the completion edge, target at the top of the address space.
    wait_req(32'h404);
    branch_flag = 1'b1; branch_target = 32'hFFFF_FFFC;
    @(negedge clk);
    branch_flag = 1'b0;
    chk("br_coinc_addr", mem_addr, 32'hFFFF_FFFC);
    chk("br_coinc_valid", {31'h0, if_valid}, 32'h0);
    chk("br_coinc_pc_hold", if_pc, 32'h400);
    wait_req(32'h0);
    chk("wrap_pc", if_pc, 32'hFFFF_FFFC);

    // Reset while a request is outstanding.
    wait_req(32'h8);
    @(negedge clk);
    chk("pre_rst_req", {31'h0, mem_req}, 32'h1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_req", {31'h0, mem_req}, 32'h0);
    chk("mid_rst_valid", {31'h0, if_valid}, 32'h0);
    chk("mid_rst_addr", mem_addr, 32'h0);
`ifdef IFETCH_PERF_CNT_EN
    chk("mid_rst_count", fetch_count, 32'h0);
`endif
    req_q.push_back(32'h0); req_q.push_back(32'h4); req_q.push_back(32'h8); req_q.push_back(32'hC);
    exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8); exp_q.push_back(32'hC);

    wait_req(32'h10);
    mon_en = 1'b0;
    chk("final_pc", if_pc, 32'hC);
`ifdef IFETCH_PERF_CNT_EN
    chk("final_count", fetch_count, 32'd4);
`endif
    chk("req_q_drained", req_q.size(), 32'd0);
    chk("exp_q_drained", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
